// File: rtl/fwd_bypass_net_if.sv
// Issue/EX boundary bundle for the operand bypass network.
// Master drives issue, producer-stage and EX-consume signals; slave is the bypass network.
interface fwd_bypass_net_if #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 3,
   parameter int CNT_W   = 16
);
   logic                        id_valid;
   logic                        id_ready;
   logic [NUM_SRC*ADDR_W-1:0]   id_src_addr;
   logic [NUM_SRC*DATA_W-1:0]   id_src_rdata;
   logic                        id_we;
   logic [ADDR_W-1:0]           id_waddr;
   logic [DEPTH*DATA_W-1:0]     stage_data;
   logic [DEPTH-1:0]            stage_rdy;
   logic                        flush;
   logic                        ex_valid;
   logic                        ex_ready;
   logic [NUM_SRC*DATA_W-1:0]   ex_rdata;
   logic [CNT_W-1:0]            stall_cnt;

   modport master (
      output id_valid, id_src_addr, id_src_rdata, id_we, id_waddr,
             stage_data, stage_rdy, flush, ex_ready,
      input  id_ready, ex_valid, ex_rdata, stall_cnt
   );

   modport slave (
      input  id_valid, id_src_addr, id_src_rdata, id_we, id_waddr,
             stage_data, stage_rdy, flush, ex_ready,
      output id_ready, ex_valid, ex_rdata, stall_cnt
   );
endinterface

// File: rtl/fwd_bypass_net.sv
// Operand bypass: youngest ready producer, else register file; load-use stalls issue.
// Operands resolve in the issue cycle and appear on ex_rdata one cycle later; EX backpressure holds issue.
module fwd_bypass_net #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 3,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   fwd_bypass_net_if.slave    bus
);

   typedef struct packed {
      logic              v;
      logic [ADDR_W-1:0] waddr;
   } trk_t;

   trk_t                       r_trk [DEPTH];
   logic                       r_ex_valid;
   logic [NUM_SRC*DATA_W-1:0]  r_ex_rdata;
   logic [CNT_W-1:0]           r_stall_cnt;

   logic [NUM_SRC*DATA_W-1:0]  w_opnd;
   logic [NUM_SRC-1:0]         w_src_haz;
   logic                       w_hazard;
   logic                       w_id_ready;
   logic                       w_id_fire;
   logic                       w_ex_fire;

   // Scan oldest to youngest so the youngest match overwrites; older matches never mask a pending load.
   always_comb begin
      w_opnd    = '0;
      w_src_haz = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         if (bus.id_src_addr[s*ADDR_W +: ADDR_W] != '0) begin
            w_opnd[s*DATA_W +: DATA_W] = bus.id_src_rdata[s*DATA_W +: DATA_W];
            for (int k = DEPTH - 1; k >= 0; k--) begin
               if (r_trk[k].v && (r_trk[k].waddr == bus.id_src_addr[s*ADDR_W +: ADDR_W])) begin
                  w_src_haz[s]               = !bus.stage_rdy[k];
                  w_opnd[s*DATA_W +: DATA_W] = bus.stage_data[k*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

   assign w_hazard   = |w_src_haz;
   assign w_ex_fire  = r_ex_valid && bus.ex_ready;
   assign w_id_ready = !w_hazard && !bus.flush && (!r_ex_valid || bus.ex_ready);
   assign w_id_fire  = bus.id_valid && w_id_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_valid  <= 1'b0;
         r_ex_rdata  <= '0;
         r_stall_cnt <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            r_trk[k] <= '0;
         end
      end else begin
         if (w_id_fire) begin
            r_ex_valid <= 1'b1;
            r_ex_rdata <= w_opnd;
            r_trk[0]   <= '{v: bus.id_we && (bus.id_waddr != '0), waddr: bus.id_waddr};
         end else if (w_ex_fire || bus.flush) begin
            r_ex_valid <= 1'b0;
            r_trk[0].v <= 1'b0;
         end
         // A flushed EX instruction never reaches MEM, even if EX consumed it in the same cycle.
         for (int k = 1; k < DEPTH; k++) begin
            if (k == 1) begin
               r_trk[k] <= (w_ex_fire && !bus.flush) ? r_trk[0] : '0;
            end else begin
               r_trk[k] <= r_trk[k-1];
            end
         end
         if (bus.id_valid && w_hazard && !bus.flush && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
      end
   end

   assign bus.id_ready  = w_id_ready;
   assign bus.ex_valid  = r_ex_valid;
   assign bus.ex_rdata  = r_ex_rdata;
   assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_bypass_net.sv
// Scoreboarded bench for fwd_bypass_net; a second instance with a 4-bit stall counter shares the stimulus.
module tb_fwd_bypass_net;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;
   logic [63:0] sb [$];
   logic [63:0] m_exp;

   fwd_bypass_net_if #(.DATA_W(32), .ADDR_W(5), .NUM_SRC(2), .DEPTH(3), .CNT_W(16)) bus ();
   fwd_bypass_net_if #(.DATA_W(32), .ADDR_W(5), .NUM_SRC(2), .DEPTH(3), .CNT_W(4))  busb ();

   fwd_bypass_net #(.DATA_W(32), .ADDR_W(5), .NUM_SRC(2), .DEPTH(3), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   fwd_bypass_net #(.DATA_W(32), .ADDR_W(5), .NUM_SRC(2), .DEPTH(3), .CNT_W(4)) dut_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (busb)
   );

   assign busb.id_valid     = bus.id_valid;
   assign busb.id_src_addr  = bus.id_src_addr;
   assign busb.id_src_rdata = bus.id_src_rdata;
   assign busb.id_we        = bus.id_we;
   assign busb.id_waddr     = bus.id_waddr;
   assign busb.stage_data   = bus.stage_data;
   assign busb.stage_rdy    = bus.stage_rdy;
   assign busb.flush        = bus.flush;
   assign busb.ex_ready     = bus.ex_ready;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] r0, input logic [31:0] r1,
                        input logic we, input logic [4:0] wa);
      bus.id_valid     = v;
      bus.id_src_addr  = {a1, a0};
      bus.id_src_rdata = {r1, r0};
      bus.id_we        = we;
      bus.id_waddr     = wa;
   endtask

   // Every instruction EX consumes must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && bus.ex_valid && bus.ex_ready && !bus.flush) begin
         if (sb.size() == 0) begin
            check_eq("sb_underflow", 64'd1, 64'd0);
         end else begin
            m_exp = sb.pop_front();
            check_eq("ex_rdata", bus.ex_rdata, m_exp);
         end
      end
   end

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
      bus.stage_data = '0;
      bus.stage_rdy  = 3'b111;
      bus.flush      = 1'b0;
      bus.ex_ready   = 1'b1;
      tick();
      tick();
      check_eq("rst_ex_valid", {63'd0, bus.ex_valid}, 64'd0);
      check_eq("rst_ex_rdata", bus.ex_rdata, 64'd0);
      check_eq("rst_stall", {48'd0, bus.stall_cnt}, 64'd0);
      check_eq("rst_id_ready", {63'd0, bus.id_ready}, 64'd1);
      rst_n = 1'b1;

      // no dependency
      drive(1'b1, 5'd1, 5'd2, 32'h11, 32'h22, 1'b1, 5'd3);
      #1 check_eq("nodep_rdy", {63'd0, bus.id_ready}, 64'd1);
      sb.push_back({32'h22, 32'h11});
      tick();
      check_eq("nodep_exv", {63'd0, bus.ex_valid}, 64'd1);
      check_eq("nodep_stall", {48'd0, bus.stall_cnt}, 64'd0);

      // EX forward of r3; r0 source reads as zero
      bus.stage_data = {32'h0, 32'h0, 32'hDEAD};
      drive(1'b1, 5'd3, 5'd0, 32'h99, 32'h55, 1'b1, 5'd4);
      #1 check_eq("exfwd_rdy", {63'd0, bus.id_ready}, 64'd1);
      sb.push_back({32'h0, 32'hDEAD});
      tick();
      drive(1'b1, 5'd7, 5'd8, 32'h70, 32'h80, 1'b1, 5'd9);
      sb.push_back({32'h80, 32'h70});
      tick();
      drive(1'b1, 5'd7, 5'd8, 32'h70, 32'h80, 1'b1, 5'd4);
      sb.push_back({32'h80, 32'h70});
      tick();

      // r4 at T0 and T2, r9 at T1; instruction writes r0
      bus.stage_data = {32'hB, 32'h91, 32'hA};
      drive(1'b1, 5'd4, 5'd9, 32'hFF, 32'hFF, 1'b1, 5'd0);
      #1 check_eq("young_rdy", {63'd0, bus.id_ready}, 64'd1);
      sb.push_back({32'h91, 32'hA});
      tick();

      // r0 source with r0 writer in EX
      drive(1'b1, 5'd0, 5'd1, 32'h1234, 32'h15, 1'b1, 5'd5);
      #1 check_eq("r0_rdy", {63'd0, bus.id_ready}, 64'd1);
      sb.push_back({32'h15, 32'h0});
      tick();

      // load-use on r5 as the load walks EX -> MEM -> WB
      bus.stage_rdy  = 3'b110;
      bus.stage_data = {32'h5A5A, 32'h0, 32'h0};
      drive(1'b1, 5'd5, 5'd0, 32'h77, 32'h0, 1'b1, 5'd6);
      #1 check_eq("lu_rdy1", {63'd0, bus.id_ready}, 64'd0);
      tick();
      check_eq("lu_stall1", {48'd0, bus.stall_cnt}, 64'd1);
      bus.stage_rdy = 3'b101;
      #1 check_eq("lu_rdy2", {63'd0, bus.id_ready}, 64'd0);
      tick();
      check_eq("lu_stall2", {48'd0, bus.stall_cnt}, 64'd2);
      check_eq("lu_stall2_sat", {60'd0, busb.stall_cnt}, 64'd2);
      bus.stage_rdy = 3'b111;
      #1 check_eq("lu_rdy3", {63'd0, bus.id_ready}, 64'd1);
      sb.push_back({32'h0, 32'h5A5A});
      tick();
      check_eq("lu_stall3", {48'd0, bus.stall_cnt}, 64'd2);

      // EX backpressure
      bus.ex_ready = 1'b0;
      drive(1'b1, 5'd10, 5'd11, 32'hAA, 32'hBB, 1'b1, 5'd12);
      #1 check_eq("bp_rdy", {63'd0, bus.id_ready}, 64'd0);
      tick();
      check_eq("bp_hold", bus.ex_rdata, {32'h0, 32'h5A5A});
      check_eq("bp_stall", {48'd0, bus.stall_cnt}, 64'd2);
      bus.ex_ready = 1'b1;
      #1 check_eq("bp_rel_rdy", {63'd0, bus.id_ready}, 64'd1);
      tick();
      check_eq("bp_next", bus.ex_rdata, {32'hBB, 32'hAA});

      // flush with ex_ready high; a hazarding issue during flush is not a stall
      bus.flush     = 1'b1;
      bus.stage_rdy = 3'b000;
      drive(1'b1, 5'd12, 5'd0, 32'h0, 32'h0, 1'b1, 5'd13);
      #1 check_eq("fl_rdy", {63'd0, bus.id_ready}, 64'd0);
      tick();
      bus.flush = 1'b0;
      check_eq("fl_exv", {63'd0, bus.ex_valid}, 64'd0);
      check_eq("fl_stall", {48'd0, bus.stall_cnt}, 64'd2);

      // r12 must not be tracked in MEM after the flush
      bus.ex_ready = 1'b0;
      drive(1'b1, 5'd12, 5'd0, 32'hC, 32'h0, 1'b1, 5'd13);
      #1 check_eq("fl_t1_rdy", {63'd0, bus.id_ready}, 64'd1);
      tick();
      check_eq("fl_t1_exv", {63'd0, bus.ex_valid}, 64'd1);
      check_eq("fl_t1_data", bus.ex_rdata, {32'h0, 32'hC});

      // 20 hazard cycles: wide counter 22, 4-bit counter saturates
      drive(1'b1, 5'd13, 5'd0, 32'h1313, 32'h0, 1'b1, 5'd14);
      #1 check_eq("sat_rdy", {63'd0, bus.id_ready}, 64'd0);
      for (int i = 0; i < 20; i++) tick();
      check_eq("sat_wide", {48'd0, bus.stall_cnt}, 64'd22);
      check_eq("sat_narrow", {60'd0, busb.stall_cnt}, 64'd15);

      // reset mid-stall
      #2 rst_n = 1'b0;
      #1;
      check_eq("mrst_exv", {63'd0, bus.ex_valid}, 64'd0);
      check_eq("mrst_rdata", bus.ex_rdata, 64'd0);
      check_eq("mrst_stall", {48'd0, bus.stall_cnt}, 64'd0);
      check_eq("mrst_stall_sat", {60'd0, busb.stall_cnt}, 64'd0);
      check_eq("mrst_rdy", {63'd0, bus.id_ready}, 64'd1);
      tick();
      rst_n        = 1'b1;
      bus.ex_ready = 1'b1;
      #1 check_eq("post_rst_rdy", {63'd0, bus.id_ready}, 64'd1);
      sb.push_back({32'h0, 32'h1313});
      tick();
      drive(1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
      tick();
      tick();
      check_eq("sb_drained", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
